// File: rtl/microwave_timer_ctrl.sv
// Microwave timer sequencer: keypad digit entry, counter load/clear strobes,
// the once-per-second countdown enable and the cook/pause/done flow.
module microwave_timer_ctrl #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned BEEP_CYCLES = 100000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] entry_min,
    output logic [3:0] entry_sec_tens,
    output logic [3:0] entry_sec_ones,
    output logic       timer_loadn,
    output logic       timer_clearn,
    output logic       timer_enable,
    output logic       magnetron_on,
    output logic       done_beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        LOAD  = 3'd2,
        COOK  = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);

    state_t           st_q, st_nx;
    logic [3:0]       min_q, tens_q, ones_q;
    logic [CNT_W-1:0] tick_cnt, beep_cnt;
    logic             clearn_q;
    logic             key_ok, entry_nz;

    // A digit is refused once minutes is occupied or when it would push a
    // value above 5 into the seconds-tens position.
    assign key_ok   = key_valid && (key_digit <= 4'd9) && (ones_q <= 4'd5) && (min_q == 4'd0);
    assign entry_nz = (min_q | tens_q | ones_q) != 4'd0;

    always_comb begin
        st_nx = st_q;
        unique case (st_q)
            IDLE, ENTRY: begin
                if (stop)
                    st_nx = IDLE;
                else if (start) begin
                    if (door_closed && entry_nz)
                        st_nx = LOAD;
                end else if (key_ok)
                    st_nx = ENTRY;
            end
            LOAD:  st_nx = COOK;
            COOK: begin
                if (stop || !door_closed)
                    st_nx = PAUSE;
                else if (timer_zero)
                    st_nx = DONE;
            end
            PAUSE: begin
                if (stop)
                    st_nx = IDLE;
                else if (start && door_closed)
                    st_nx = COOK;
            end
            DONE: begin
                if (stop || (beep_cnt == BEEP_LAST))
                    st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            st_q         <= IDLE;
            min_q        <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            tick_cnt     <= '0;
            beep_cnt     <= '0;
            clearn_q     <= 1'b1;
            timer_loadn  <= 1'b1;
            timer_enable <= 1'b0;
            magnetron_on <= 1'b0;
            done_beep    <= 1'b0;
        end else begin
            st_q         <= st_nx;
            timer_loadn  <= (st_nx != LOAD);
            magnetron_on <= (st_nx == COOK);
            done_beep    <= (st_nx == DONE);
            clearn_q     <= !((st_nx == IDLE) && ((st_q == PAUSE) || (st_q == DONE)));
            timer_enable <= 1'b0;
            unique case (st_q)
                IDLE, ENTRY: begin
                    if (stop) begin
                        min_q  <= '0;
                        tens_q <= '0;
                        ones_q <= '0;
                    end else if (!start && key_ok) begin
                        min_q  <= tens_q;
                        tens_q <= ones_q;
                        ones_q <= key_digit;
                    end
                end
                LOAD: tick_cnt <= '0;
                COOK: begin
                    // Tick only advances while cooking continues; pause keeps the phase.
                    if (st_nx == COOK) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt     <= '0;
                            timer_enable <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    if (st_nx == DONE)
                        beep_cnt <= '0;
                end
                PAUSE: begin
                    if (stop) begin
                        min_q  <= '0;
                        tens_q <= '0;
                        ones_q <= '0;
                    end
                end
                DONE: begin
                    if (st_nx == IDLE) begin
                        min_q  <= '0;
                        tens_q <= '0;
                        ones_q <= '0;
                    end else begin
                        beep_cnt <= beep_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign timer_clearn   = clearn_q & ~clear;
    assign entry_min      = min_q;
    assign entry_sec_tens = tens_q;
    assign entry_sec_ones = ones_q;
    assign state          = st_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus random keypad/door
// traffic, all checked against a seconds-level behavioural model.
module tb_microwave_timer_ctrl;

    localparam int TICK = 4;
    localparam int BEEP = 3;
    localparam int S_IDLE = 0, S_ENTRY = 1, S_LOAD = 2, S_COOK = 3, S_PAUSE = 4, S_DONE = 5;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic       timer_zero;
    logic [3:0] entry_min, entry_sec_tens, entry_sec_ones;
    logic       timer_loadn, timer_clearn, timer_enable, magnetron_on, done_beep;
    logic [2:0] state;

    logic door = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model: entry kept as a decimal number, beep as cycles remaining
    int m_state, m_val, m_phase, m_beep_left;
    bit m_en, m_clrlow;

    // external countdown counters modelled as total seconds remaining
    int rem = 0;

    microwave_timer_ctrl #(.TICK_DIV(TICK), .BEEP_CYCLES(BEEP), .CNT_W(32)) dut (
        .clock(clock), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
        .entry_min(entry_min), .entry_sec_tens(entry_sec_tens), .entry_sec_ones(entry_sec_ones),
        .timer_loadn(timer_loadn), .timer_clearn(timer_clearn), .timer_enable(timer_enable),
        .magnetron_on(magnetron_on), .done_beep(done_beep), .state(state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!timer_clearn)
            rem <= 0;
        else if (!timer_loadn)
            rem <= int'(entry_min) * 60 + int'(entry_sec_tens) * 10 + int'(entry_sec_ones);
        else if (timer_enable && rem > 0)
            rem <= rem - 1;
    end
    assign timer_zero = (rem == 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_val = 0; m_phase = 0; m_beep_left = 0; m_en = 0; m_clrlow = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kd, input logic st,
                              input logic sp, input logic dr, input logic tz);
        int ns;
        ns = m_state;
        m_en = 0;
        m_clrlow = 0;
        case (m_state)
            S_IDLE, S_ENTRY: begin
                if (sp) begin
                    m_val = 0; ns = S_IDLE;
                end else if (st) begin
                    if (dr && m_val != 0) ns = S_LOAD;
                end else if (kv && kd <= 4'd9 && (m_val % 10) <= 5 && m_val < 100) begin
                    m_val = m_val * 10 + int'(kd); ns = S_ENTRY;
                end
            end
            S_LOAD: begin
                m_phase = 0; ns = S_COOK;
            end
            S_COOK: begin
                if (sp || !dr) ns = S_PAUSE;
                else if (tz) begin
                    ns = S_DONE; m_beep_left = BEEP;
                end else begin
                    m_phase++;
                    if (m_phase == TICK) begin
                        m_phase = 0; m_en = 1;
                    end
                end
            end
            S_PAUSE: begin
                if (sp) begin
                    ns = S_IDLE; m_val = 0; m_clrlow = 1;
                end else if (st && dr) ns = S_COOK;
            end
            S_DONE: begin
                m_beep_left--;
                if (sp || m_beep_left == 0) begin
                    ns = S_IDLE; m_val = 0; m_clrlow = 1;
                end
            end
            default: ns = S_IDLE;
        endcase
        m_state = ns;
    endtask

    task automatic check_all();
        int exp_entry;
        exp_entry = ((m_val / 100) << 8) | (((m_val / 10) % 10) << 4) | (m_val % 10);
        check("state", 32'(state), 32'(m_state));
        check("entry", 32'({entry_min, entry_sec_tens, entry_sec_ones}), 32'(exp_entry));
        check("loadn", 32'(timer_loadn), 32'(m_state != S_LOAD));
        check("clearn", 32'(timer_clearn), 32'(!clear && !m_clrlow));
        check("enable", 32'(timer_enable), 32'(m_en));
        check("magnetron", 32'(magnetron_on), 32'(m_state == S_COOK));
        check("beep", 32'(done_beep), 32'(m_state == S_DONE));
        check("enable_excl", 32'(timer_enable & (~timer_loadn | ~timer_clearn)), 32'd0);
    endtask

    task automatic step(input logic kv, input logic [3:0] kd, input logic st, input logic sp);
        key_valid = kv; key_digit = kd; start = st; stop = sp; door_closed = door;
        model_step(kv, kd, st, sp, door, timer_zero);
        @(negedge clock);
        check_all();
    endtask

    task automatic key_in(input int d);
        step(1'b1, 4'(d), 1'b0, 1'b0);
    endtask
    task automatic idle_cycle();
        step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask
    task automatic press_start();
        step(1'b0, 4'd0, 1'b1, 1'b0);
    endtask
    task automatic press_stop();
        step(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic apply_clear();
        #1 clear = 1'b1;
        model_reset();
        #1;
        check("async_magnetron", 32'(magnetron_on), 32'd0);
        check("async_clearn", 32'(timer_clearn), 32'd0);
        check("async_state", 32'(state), 32'(S_IDLE));
        check("async_enable", 32'(timer_enable), 32'd0);
        @(negedge clock);
        check_all();
        clear = 1'b0;
        #1 check_all();
    endtask

    initial begin
        int n, found;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all();
        clear = 1'b0;
        #1 check_all();

        // entry shifting and rejection rules
        key_in(1); key_in(3); key_in(0);
        check("entry_130", 32'({entry_min, entry_sec_tens, entry_sec_ones}), 32'h130);
        key_in(5);
        check("fourth_digit", 32'({entry_min, entry_sec_tens, entry_sec_ones}), 32'h130);
        press_stop();
        key_in(7); key_in(8);
        check("entry_007", 32'({entry_min, entry_sec_tens, entry_sec_ones}), 32'h007);
        key_in(12);

        // start refused with door open, and with nothing entered
        door = 1'b0;
        press_start();
        check("start_door_open", 32'(state), 32'(S_ENTRY));
        check("start_door_loadn", 32'(timer_loadn), 32'd1);
        door = 1'b1;
        press_stop();
        press_start();
        check("start_empty", 32'(state), 32'(S_IDLE));

        // full cook of 0:02
        key_in(0); key_in(2);
        press_start();
        check("load_state", 32'(state), 32'(S_LOAD));
        check("load_strobe", 32'(timer_loadn), 32'd0);
        check("load_digits", 32'({entry_min, entry_sec_tens, entry_sec_ones}), 32'h002);
        n = 0;
        for (int i = 0; i < 60 && state != 3'(S_DONE); i++) begin
            idle_cycle();
            if (timer_enable) n++;
        end
        check("done_reached", 32'(state), 32'(S_DONE));
        check("enable_pulses", 32'(n), 32'd2);
        n = 0;
        for (int i = 0; i < 10 && done_beep; i++) begin
            n++;
            idle_cycle();
        end
        check("beep_cycles", 32'(n), 32'(BEEP));
        check("done_to_idle_clearn", 32'(timer_clearn), 32'd0);
        idle_cycle();
        check("clearn_release", 32'(timer_clearn), 32'd1);

        // door opened two cycles after an enable, then resumed
        key_in(0); key_in(5);
        press_start();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            idle_cycle();
            if (timer_enable) found = 1;
        end
        check("first_enable_seen", 32'(found), 32'd1);
        idle_cycle(); idle_cycle();
        door = 1'b0;
        idle_cycle();
        check("door_pause", 32'(state), 32'(S_PAUSE));
        check("door_pause_mag", 32'(magnetron_on), 32'd0);
        idle_cycle(); idle_cycle(); idle_cycle();
        door = 1'b1;
        press_start();
        check("resume_cook", 32'(state), 32'(S_COOK));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            idle_cycle();
            n++;
            if (timer_enable) break;
        end
        check("resume_enable_delay", 32'(n), 32'd2);
        door = 1'b0;
        idle_cycle();
        door = 1'b1;
        press_stop();
        check("pause_stop_state", 32'(state), 32'(S_IDLE));
        check("pause_stop_clearn", 32'(timer_clearn), 32'd0);
        check("pause_stop_entry", 32'({entry_min, entry_sec_tens, entry_sec_ones}), 32'h000);
        idle_cycle();

        // asynchronous clear in the middle of cooking
        key_in(0); key_in(9);
        press_start();
        idle_cycle(); idle_cycle(); idle_cycle();
        check("pre_clear_cook", 32'(state), 32'(S_COOK));
        apply_clear();
        key_in(4);
        check("entry_after_clear", 32'({entry_min, entry_sec_tens, entry_sec_ones}), 32'h004);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic kv, st, sp;
            r  = int'($urandom_range(0, 99));
            kv = (r < 20);
            st = (r >= 20 && r < 28) || r == 30;
            sp = (r >= 28 && r < 31);
            if ($urandom_range(0, 99) < 3) door = ~door;
            step(kv, 4'($urandom_range(0, 11)), st, sp);
            if ($urandom_range(0, 999) == 0) apply_clear();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
